// File: rtl/pet_pkg.sv
// Shared pet-status definitions: estado codes, need-level width/limit and the
// rest-mode state type, used by stat_manager and the state-evaluation block.
package pet_pkg;

    localparam int unsigned STAT_W = 3;

    typedef logic [STAT_W-1:0] stat_t;

    localparam stat_t STAT_MAX = 3'd7;

    typedef enum logic [3:0] {
        BIEN        = 4'b0000,
        SEDIENTO    = 4'b0001,
        HAMBRIENTO  = 4'b0010,
        CANSADO     = 4'b0011,
        SUCIO       = 4'b0100,
        DESALINEADO = 4'b0101,
        ENFERMO     = 4'b0110,
        TRISTE      = 4'b0111,
        FELIZ       = 4'b1000,
        DORMIDO     = 4'b1001,
        MUERTE      = 4'b1010
    } estado_t;

    typedef enum logic {
        AWAKE   = 1'b0,
        RESTING = 1'b1
    } rest_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stat_cell.sv
// One saturating need level with its period counter: decays every PERIOD ticks,
// or recovers every REC_PERIOD ticks while recover is set; act adds INC.
module stat_cell
    import pet_pkg::*;
#(
    parameter int unsigned PERIOD     = 4,
    parameter int unsigned REC_PERIOD = 2,
    parameter int unsigned INC        = 3,
    parameter int unsigned CNT_W      = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  tick,
    input  logic  act,
    input  logic  hold,
    input  logic  recover,
    input  logic  clr,
    output stat_t level,
    output logic  rec_full
);

    localparam int unsigned SUM_W = STAT_W + 1;
    localparam logic [CNT_W-1:0] DEC_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(REC_PERIOD - 1);
    localparam logic [SUM_W-1:0] INC_W    = SUM_W'(INC);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    stat_t            level_n;
    logic [SUM_W-1:0] sum;
    logic             dec_hit;
    logic             rec_hit;

    assign sum     = {1'b0, level} + INC_W;
    assign dec_hit = tick && !recover && (cnt == DEC_LAST);
    assign rec_hit = tick && recover && (cnt == REC_LAST);

    // An action takes priority, so a coincident decay step is simply dropped.
    always_comb begin
        level_n = level;
        if (!hold) begin
            if (act) begin
                level_n = (sum > {1'b0, STAT_MAX}) ? STAT_MAX : sum[STAT_W-1:0];
            end else if (dec_hit) begin
                level_n = (level == '0) ? '0 : level - 1'b1;
            end else if (rec_hit) begin
                level_n = (level == STAT_MAX) ? STAT_MAX : level + 1'b1;
            end
        end
    end

    // Kept apart from level_n: clr depends on rec_full through the rest FSM.
    always_comb begin
        cnt_n = cnt;
        if (!hold) begin
            if (act || clr || dec_hit || rec_hit) begin
                cnt_n = '0;
            end else if (tick) begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    assign rec_full = recover && (level_n == STAT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= STAT_MAX;
            cnt   <= '0;
        end else begin
            level <= level_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: rtl/stat_manager.sv
// Pet need-level producer: time base, button edge detect, five decaying levels
// and rest mode. Define FAST_TIME_EN to force a 4-cycle time-base period.
module stat_manager
    import pet_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned P_HUM    = 4,
    parameter int unsigned P_NUT    = 6,
    parameter int unsigned P_ENE    = 8,
    parameter int unsigned P_MAN    = 10,
    parameter int unsigned P_COR    = 12,
    parameter int unsigned P_REC    = 2,
    parameter int unsigned INC      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_regar,
    input  logic        btn_alimentar,
    input  logic        btn_limpiar,
    input  logic        btn_podar,
    input  logic        btn_dormir,
    input  logic [3:0]  estado,
    output logic [2:0]  humedad,
    output logic [2:0]  nutricion,
    output logic [2:0]  energia,
    output logic [2:0]  mantenimiento,
    output logic [2:0]  cortado,
    output logic        reposando,
    output logic        tick
);

`ifdef FAST_TIME_EN
    localparam int unsigned DIV = 4;
`else
    localparam int unsigned DIV = TICK_DIV;
`endif

    localparam int unsigned PW    = width_for(DIV);
    localparam int unsigned PMAX  = max_u(max_u(max_u(P_HUM, P_NUT), max_u(P_ENE, P_MAN)),
                                          max_u(P_COR, P_REC));
    localparam int unsigned CNT_W = width_for(PMAX);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] pcnt;
    logic [4:0]    btn_now;
    logic [4:0]    btn_q;
    logic [4:0]    ev;
    logic          frozen;
    logic          act_ok;
    logic          clr_ene;
    logic          resting;
    logic [4:0]    rec_full;
    rest_state_t   state;
    rest_state_t   state_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (pcnt == PRE_LAST) begin
            pcnt <= '0;
            tick <= 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
            tick <= 1'b0;
        end
    end

    assign btn_now = {btn_dormir, btn_podar, btn_limpiar, btn_alimentar, btn_regar};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn_now;
        end
    end

    assign ev      = btn_now & ~btn_q;
    assign frozen  = (estado == MUERTE);
    assign resting = (state == RESTING);
    assign act_ok  = !frozen && !resting;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= AWAKE;
        end else begin
            state <= state_n;
        end
    end

    // Only energia's cell can raise rec_full; leaving happens on the edge it hits 7.
    always_comb begin
        state_n = state;
        if (!frozen) begin
            case (state)
                AWAKE:   if (ev[4]) state_n = RESTING;
                RESTING: if (ev[4] || (|rec_full)) state_n = AWAKE;
                default: state_n = AWAKE;
            endcase
        end
    end

    assign clr_ene   = (state_n != state);
    assign reposando = resting;

    stat_cell #(.PERIOD(P_HUM), .REC_PERIOD(P_REC), .INC(INC), .CNT_W(CNT_W)) u_hum (
        .clk(clk), .rst(rst), .tick(tick), .act(ev[0] && act_ok), .hold(frozen),
        .recover(1'b0), .clr(1'b0), .level(humedad), .rec_full(rec_full[0])
    );

    stat_cell #(.PERIOD(P_NUT), .REC_PERIOD(P_REC), .INC(INC), .CNT_W(CNT_W)) u_nut (
        .clk(clk), .rst(rst), .tick(tick), .act(ev[1] && act_ok), .hold(frozen),
        .recover(1'b0), .clr(1'b0), .level(nutricion), .rec_full(rec_full[1])
    );

    stat_cell #(.PERIOD(P_ENE), .REC_PERIOD(P_REC), .INC(INC), .CNT_W(CNT_W)) u_ene (
        .clk(clk), .rst(rst), .tick(tick), .act(1'b0), .hold(frozen),
        .recover(resting), .clr(clr_ene), .level(energia), .rec_full(rec_full[2])
    );

    stat_cell #(.PERIOD(P_MAN), .REC_PERIOD(P_REC), .INC(INC), .CNT_W(CNT_W)) u_man (
        .clk(clk), .rst(rst), .tick(tick), .act(ev[2] && act_ok), .hold(frozen),
        .recover(1'b0), .clr(1'b0), .level(mantenimiento), .rec_full(rec_full[3])
    );

    stat_cell #(.PERIOD(P_COR), .REC_PERIOD(P_REC), .INC(INC), .CNT_W(CNT_W)) u_cor (
        .clk(clk), .rst(rst), .tick(tick), .act(ev[3] && act_ok), .hold(frozen),
        .recover(1'b0), .clr(1'b0), .level(cortado), .rec_full(rec_full[4])
    );

endmodule
